// File: rtl/rf_down_stream_ctrl.sv
// Startup/gating sequencer for the RF 4-to-2 downsampler: reset hold, transient discard, underflow watch.
// Latency: dp_tvalid 1 cycle, o_tvalid 0 cycles; no backpressure (valid-only stream, gaps flagged as underflow).
module rf_down_stream_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int DISCARD_BEATS = 24,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic aresetn,
    input  logic enable,
    input  logic clear_status,
    input  logic i_tvalid,
    output logic dp_rst,
    output logic dp_tvalid,
    input  logic dp_o_tvalid,
    output logic o_tvalid,
    output logic running,
    output logic underflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_PRIME = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISC_LOAD = (DISCARD_BEATS > 0) ? CNT_W'(DISCARD_BEATS - 1) : {CNT_W{1'b0}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_zero;
    logic             fed_now;
    logic             fed_nxt;
    logic             uf_set;

    assign cnt_zero = (cnt == {CNT_W{1'b0}});

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if ((state != ST_IDLE) && !enable) begin
            // Disable abandons any progress; re-enable restarts from the reset hold.
            state_nxt = ST_IDLE;
            cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt = ST_RESET;
                        cnt_nxt   = RST_LOAD;
                    end
                end
                ST_RESET: begin
                    if (cnt_zero) begin
                        if (DISCARD_BEATS == 0) begin
                            state_nxt = ST_RUN;
                            cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            state_nxt = ST_PRIME;
                            cnt_nxt   = DISC_LOAD;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_PRIME: begin
                    // Only real output beats count toward the filter transient.
                    if (dp_o_tvalid) begin
                        if (cnt_zero) begin
                            state_nxt = ST_RUN;
                            cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Feed the datapath only once it is already out of reset and stays out of it.
    assign fed_now = (state == ST_PRIME) || (state == ST_RUN);
    assign fed_nxt = (state_nxt == ST_PRIME) || (state_nxt == ST_RUN);
    assign uf_set  = (state == ST_RUN) && !i_tvalid;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            cnt       <= {CNT_W{1'b0}};
            dp_rst    <= 1'b1;
            running   <= 1'b0;
            dp_tvalid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dp_rst    <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
            running   <= (state_nxt == ST_RUN);
            dp_tvalid <= i_tvalid && fed_now && fed_nxt;
            underflow <= uf_set || (underflow && !clear_status);
        end
    end

    // Combinational so it stays aligned with downsampler tdata, which bypasses this block.
    assign o_tvalid = dp_o_tvalid && running;

endmodule

// File: tb/tb_rf_down_stream_ctrl.sv
// Bench for rf_down_stream_ctrl: two configurations (3 and 0 discard beats) against a cycle/beat-count model.
module tb_rf_down_stream_ctrl;

    logic clk = 1'b0;
    logic aresetn, enable, clr, itv;
    logic [1:0] dpo;
    logic a_dp_rst, a_dp_tvalid, a_o_tvalid, a_running, a_uf;
    logic b_dp_rst, b_dp_tvalid, b_o_tvalid, b_running, b_uf;
    logic [10:0] dly_a, dly_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: sequence age in cycles since enable and beats seen after reset release.
    bit m_act  [2];
    int m_age  [2];
    int m_beats[2];
    bit m_uf   [2];
    bit m_dpv  [2];

    always #5 clk = ~clk;

    rf_down_stream_ctrl #(.RST_CYCLES(4), .DISCARD_BEATS(3), .CNT_W(8)) dut_a (
        .clk(clk), .aresetn(aresetn), .enable(enable), .clear_status(clr),
        .i_tvalid(itv), .dp_rst(a_dp_rst), .dp_tvalid(a_dp_tvalid),
        .dp_o_tvalid(dpo[0]), .o_tvalid(a_o_tvalid), .running(a_running), .underflow(a_uf)
    );

    rf_down_stream_ctrl #(.RST_CYCLES(4), .DISCARD_BEATS(0), .CNT_W(8)) dut_b (
        .clk(clk), .aresetn(aresetn), .enable(enable), .clear_status(clr),
        .i_tvalid(itv), .dp_rst(b_dp_rst), .dp_tvalid(b_dp_tvalid),
        .dp_o_tvalid(dpo[1]), .o_tvalid(b_o_tvalid), .running(b_running), .underflow(b_uf)
    );

    function automatic int rst_len(input int i);
        return 4;
    endfunction

    function automatic int disc_len(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic bit past_rst(input int i);
        return m_act[i] && (m_age[i] >= rst_len(i));
    endfunction

    function automatic bit in_run(input int i);
        return past_rst(i) && (m_beats[i] >= disc_len(i));
    endfunction

    task automatic chk(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0; m_age[i] <= 0; m_beats[i] <= 0;
                m_uf[i]  <= 1'b0; m_dpv[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_uf[i]  <= (in_run(i) && !itv) || (m_uf[i] && !clr);
                m_dpv[i] <= itv && past_rst(i) && enable;
                if (!m_act[i]) begin
                    if (enable) begin
                        m_act[i] <= 1'b1; m_age[i] <= 0; m_beats[i] <= 0;
                    end
                end else if (!enable) begin
                    m_act[i] <= 1'b0;
                end else begin
                    if (past_rst(i) && (m_beats[i] < disc_len(i)) && dpo[i])
                        m_beats[i] <= m_beats[i] + 1;
                    if (m_age[i] < 1000000)
                        m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("A.dp_rst",    a_dp_rst,    !past_rst(0));
        chk("A.dp_tvalid", a_dp_tvalid, m_dpv[0]);
        chk("A.running",   a_running,   in_run(0));
        chk("A.o_tvalid",  a_o_tvalid,  in_run(0) && dpo[0]);
        chk("A.underflow", a_uf,        m_uf[0]);
        chk("B.dp_rst",    b_dp_rst,    !past_rst(1));
        chk("B.dp_tvalid", b_dp_tvalid, m_dpv[1]);
        chk("B.running",   b_running,   in_run(1));
        chk("B.o_tvalid",  b_o_tvalid,  in_run(1) && dpo[1]);
        chk("B.underflow", b_uf,        m_uf[1]);
    end

    initial begin
        aresetn = 1'b1; enable = 1'b0; clr = 1'b0; itv = 1'b1; dpo = 2'b00;
        dly_a = '0; dly_b = '0;
        #1 aresetn = 1'b0;
        #1;
        chk("rst.dp_rst",    a_dp_rst,    1'b1);
        chk("rst.dp_tvalid", a_dp_tvalid, 1'b0);
        chk("rst.running",   a_running,   1'b0);
        chk("rst.o_tvalid",  a_o_tvalid,  1'b0);
        chk("rst.underflow", a_uf,        1'b0);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        repeat (3) @(posedge clk);

        // Startup, discard, then gaps and clears in RUN; dp_o_tvalid echoes dp_tvalid 10 cycles later.
        for (int c = 0; c < 34; c++) begin
            @(posedge clk); #1;
            dly_a = {dly_a[9:0], a_dp_tvalid};
            dly_b = {dly_b[9:0], b_dp_tvalid};
            enable = 1'b1;
            itv = !((c == 26) || (c == 30));
            clr = (c == 28) || (c == 30) || (c == 32);
            dpo = {dly_b[10], dly_a[10]};
            #3;
            chk("t1.dp_rst", a_dp_rst, c <= 4);
            if (c <= 8) chk("t1.dp_tvalid", a_dp_tvalid, c >= 6);
            if (c >= 14 && c <= 20) begin
                chk("t2.o_tvalid", a_o_tvalid, c >= 19);
                chk("t2.running",  a_running,  c >= 19);
            end
            if (c >= 3 && c <= 17) begin
                chk("t5.running",  b_running,  c >= 5);
                chk("t5.o_tvalid", b_o_tvalid, c >= 16);
            end
            if (c >= 25) chk("t3.underflow", a_uf, (c == 27) || (c == 28) || (c == 31) || (c == 32));
        end

        enable = 1'b0; clr = 1'b1; itv = 1'b1; dpo = 2'b00;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;

        // Disable after one discarded beat, re-enable, then a gap and an async reset in RUN.
        for (int d = 0; d < 23; d++) begin
            @(posedge clk); #1;
            enable = !((d >= 7) && (d <= 9));
            itv = (d != 20);
            dpo = {2{(d == 6) || (d >= 16)}};
            #3;
            if (d >= 5 && d <= 15) chk("t4.dp_rst", a_dp_rst, (d >= 8) && (d <= 14));
            if (d >= 16 && d <= 19) chk("t4.o_tvalid", a_o_tvalid, d == 19);
            if (d >= 15) chk("t4.running", a_running, d >= 19);
            if (d == 6) chk("t5.first_beat", b_o_tvalid, 1'b1);
            if (d >= 20) chk("t6.uf_before", a_uf, d >= 21);
        end
        @(posedge clk); #1;
        dpo = 2'b11;
        #1 chk("t6.o_tvalid_before", a_o_tvalid, 1'b1);
        #1 aresetn = 1'b0;
        #1;
        chk("t6.dp_rst",    a_dp_rst,   1'b1);
        chk("t6.o_tvalid",  a_o_tvalid, 1'b0);
        chk("t6.underflow", a_uf,       1'b0);
        chk("t6.running",   a_running,  1'b0);
        @(posedge clk); #1 aresetn = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            aresetn = 1'b1;
            if ($urandom_range(0, 29) == 0) enable = !enable;
            itv = ($urandom_range(0, 11) != 0);
            clr = ($urandom_range(0, 14) == 0);
            dpo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 699) == 0) begin
                #2 aresetn = 1'b0;
            end
        end
        @(posedge clk); #1 aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
